// File: rtl/axppa_error_monitor.sv
// Streaming error-metric collector for approximate adders: error rate, max/summed error distance.
// Optional signed bias accumulator is built when AXPPA_ERR_BIAS_EN is defined.
module axppa_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [CNT_W-1:0]                cfg_count,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                op_a,
    input  logic [WIDTH-1:0]                op_b,
    input  logic [WIDTH:0]                  approx_sum,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_W-1:0]                sample_count,
    output logic [CNT_W-1:0]                err_count,
    output logic [WIDTH:0]                  max_ed,
    output logic [CNT_W+WIDTH:0]            sum_ed,
    output logic signed [CNT_W+WIDTH+1:0]   err_bias
);

    localparam int SW   = WIDTH + 1;          // sum / error-distance width
    localparam int DW   = WIDTH + 2;          // signed difference width
    localparam int SUMW = CNT_W + WIDTH + 1;
    localparam int BW   = CNT_W + WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;

    logic accept;
    logic clear;

    // S1: captured sample
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [SW-1:0]    s1_approx_q;
    logic [SW-1:0]    s1_exact;

    // S2: error terms
    logic             s2_valid_q;
    logic [SW-1:0]    s2_abs_q;
    logic             s2_mismatch_q;
    logic [SW-1:0]    s1_abs;
    logic             s1_mismatch;

    // S3: accumulators
    logic [CNT_W-1:0] sample_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic [SW-1:0]    max_ed_q;
    logic [SUMW-1:0]  sum_ed_q;

    assign accept = in_valid && (state_q == ST_RUN);
    assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    remain_d = cfg_count;
                    state_d  = (cfg_count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // S1: capture operands; exact sum formed from the captured copies
    // ------------------------------------------------------------------
    // NOTE: datapath registers are plain flops, not a memory, so they take the reset like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_approx_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q      <= op_a;
                s1_b_q      <= op_b;
                s1_approx_q <= approx_sum;
            end
        end
    end

    assign s1_exact    = SW'(s1_a_q) + SW'(s1_b_q);
    assign s1_mismatch = (s1_approx_q != s1_exact);

`ifdef AXPPA_ERR_BIAS_EN
    logic signed [DW-1:0] s1_diff;
    logic signed [DW-1:0] s2_diff_q;
    logic signed [BW-1:0] err_bias_q;

    assign s1_diff = signed'(DW'(s1_approx_q)) - signed'(DW'(s1_exact));
    assign s1_abs  = s1_diff[DW-1] ? SW'(-s1_diff) : SW'(s1_diff);
`else
    // Without the bias path only the magnitude is needed, so skip the signed subtract.
    assign s1_abs = (s1_approx_q >= s1_exact) ? (s1_approx_q - s1_exact)
                                               : (s1_exact - s1_approx_q);
`endif

    // ------------------------------------------------------------------
    // S2: register error terms
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_abs_q      <= '0;
            s2_mismatch_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_abs_q      <= s1_abs;
                s2_mismatch_q <= s1_mismatch;
            end
        end
    end

`ifdef AXPPA_ERR_BIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_diff_q <= '0;
        end else if (s1_valid_q) begin
            s2_diff_q <= s1_diff;
        end
    end
`endif

    // ------------------------------------------------------------------
    // S3: accumulators; a start in IDLE/DONE wins over any update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
        end else if (clear) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
        end else if (s2_valid_q) begin
            sample_count_q <= sample_count_q + CNT_W'(1);
            err_count_q    <= err_count_q + CNT_W'(s2_mismatch_q);
            sum_ed_q       <= sum_ed_q + SUMW'(s2_abs_q);
            if (s2_abs_q > max_ed_q) begin
                max_ed_q <= s2_abs_q;
            end
        end
    end

`ifdef AXPPA_ERR_BIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bias_q <= '0;
        end else if (clear) begin
            err_bias_q <= '0;
        end else if (s2_valid_q) begin
            err_bias_q <= err_bias_q + BW'(s2_diff_q);
        end
    end

    assign err_bias = err_bias_q;
`else
    assign err_bias = '0;
`endif

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Self-checking bench for axppa_error_monitor: directed scenarios plus randomized runs
// checked against a sample-level reference model (totals per run, visibility two edges after accept).
module tb_axppa_error_monitor;

    localparam int W  = 16;
    localparam int CW = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [CW-1:0]           cfg_count;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            op_a;
    logic [W-1:0]            op_b;
    logic [W:0]              approx_sum;
    logic                    busy;
    logic                    done;
    logic [CW-1:0]           sample_count;
    logic [CW-1:0]           err_count;
    logic [W:0]              max_ed;
    logic [CW+W:0]           sum_ed;
    logic signed [CW+W+1:0]  err_bias;

    axppa_error_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_count    (cfg_count),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .approx_sum   (approx_sum),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .max_ed       (max_ed),
        .sum_ed       (sum_ed),
        .err_bias     (err_bias)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;

    // Reference model: run totals over accepted samples, plus cumulative count per edge.
    longint m_samples, m_errs, m_max, m_sum, m_bias, m_rem;
    int     m_cum_q[$];

    function automatic void model_clear(input longint cnt);
        m_samples = 0;
        m_errs    = 0;
        m_max     = 0;
        m_sum     = 0;
        m_bias    = 0;
        m_rem     = cnt;
        m_cum_q   = {0, 0};
    endfunction

    function automatic longint exp_bias();
`ifdef AXPPA_ERR_BIAS_EN
        return m_bias;
`else
        return 0;
`endif
    endfunction

    task automatic pulse_start(input longint cnt);
        start     = 1'b1;
        cfg_count = CW'(cnt);
        in_valid  = 1'b0;
        n_vec++;
        @(negedge clk);
        start = 1'b0;
        model_clear(cnt);
    endtask

    // Drives one cycle from a negedge; returns in_ready as seen during that cycle.
    task automatic offer(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] s, input bit st, output bit rdy);
        longint ex, d, ad;
        in_valid   = v;
        op_a       = a;
        op_b       = b;
        approx_sum = s;
        start      = st;
        rdy        = in_ready;
        n_vec++;
        if (v && m_rem > 0) begin
            ex = longint'(a) + longint'(b);
            d  = longint'(s) - ex;
            ad = (d < 0) ? -d : d;
            m_samples++;
            if (d != 0) m_errs++;
            if (ad > m_max) m_max = ad;
            m_sum  += ad;
            m_bias += d;
            m_rem--;
        end
        m_cum_q.push_back(int'(m_samples));
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bit rdy;
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; cfg_count = '0;
        op_a = '0; op_b = '0; approx_sum = '0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {in_ready, busy, done}); end
        n_cmp++; if (sample_count !== 0 || err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || err_bias !== 0) begin n_err++; $display("FAIL reset_stats: got %0d/%0d/%0d/%0d/%0d expected all 0", sample_count, err_count, max_ed, sum_ed, err_bias); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear(0);
        // Reset in the middle of a run, three samples in.
        pulse_start(8);
        for (int i = 0; i < 3; i++) offer(1'b1, 16'h0100 + W'(i), 16'h0010, 17'h00100, 1'b0, rdy);
        offer(1'b0, '0, '0, '0, 1'b0, rdy);
        offer(1'b0, '0, '0, '0, 1'b0, rdy);
        n_cmp++; if (sample_count !== 3) begin n_err++; $display("FAIL midrun_count: got %0d expected 3", sample_count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready, busy, done} !== 3'b000) begin n_err++; $display("FAIL midrun_reset_flags: got %b expected 000", {in_ready, busy, done}); end
        n_cmp++; if (sample_count !== 0 || err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || err_bias !== 0) begin n_err++; $display("FAIL midrun_reset_stats: got %0d/%0d/%0d/%0d/%0d expected all 0", sample_count, err_count, max_ed, sum_ed, err_bias); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(0);
    endtask

    task automatic test_exact();
        logic [W-1:0] av [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
        logic [W-1:0] bv [4] = '{16'h0F0F, 16'hFFFF, 16'h0000, 16'h8000};
        bit rdy;
        int cyc;
        pulse_start(4);
        n_cmp++; if ({busy, done, in_ready} !== 3'b101) begin n_err++; $display("FAIL exact_armed: got %b expected 101", {busy, done, in_ready}); end
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, av[i], bv[i], {1'b0, av[i]} + {1'b0, bv[i]}, 1'b0, rdy);
            n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL exact_ready[%0d]: got %b expected 1", i, rdy); end
        end
        wait_done(cyc);
        n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL exact_done_latency: got %0d expected 3", cyc); end
        n_cmp++; if (sample_count !== 4 || err_count !== 0 || max_ed !== 0 || sum_ed !== 0 || err_bias !== 0) begin n_err++; $display("FAIL exact_stats: got %0d/%0d/%0d/%0d/%0d expected 4/0/0/0/0", sample_count, err_count, max_ed, sum_ed, err_bias); end
    endtask

    task automatic test_low_bit();
        bit rdy;
        int cyc;
        longint eb;
        pulse_start(2);
        offer(1'b1, 16'h003F, 16'h0001, 17'h0003E, 1'b0, rdy);
        offer(1'b1, 16'hFFFF, 16'h0001, 17'h0FFFE, 1'b0, rdy);
        wait_done(cyc);
`ifdef AXPPA_ERR_BIAS_EN
        eb = -4;
`else
        eb = 0;
`endif
        n_cmp++; if (err_count !== 2 || max_ed !== 2 || sum_ed !== 4) begin n_err++; $display("FAIL lowbit_stats: got err=%0d max=%0d sum=%0d expected 2/2/4", err_count, max_ed, sum_ed); end
        n_cmp++; if (err_bias !== 50'(eb)) begin n_err++; $display("FAIL lowbit_bias: got %0d expected %0d", err_bias, eb); end
    endtask

    task automatic test_zero_count();
        bit rdy;
        pulse_start(0);
        n_cmp++; if ({done, busy, in_ready} !== 3'b100) begin n_err++; $display("FAIL zero_flags: got %b expected 100", {done, busy, in_ready}); end
        n_cmp++; if (max_ed !== 0 || sum_ed !== 0 || err_count !== 0 || err_bias !== 0) begin n_err++; $display("FAIL zero_clear: got max=%0d sum=%0d err=%0d bias=%0d expected 0", max_ed, sum_ed, err_count, err_bias); end
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 16'h0001, 16'h0001, 17'h00005, 1'b0, rdy);
            n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL zero_ready[%0d]: got %b expected 0", i, rdy); end
        end
        n_cmp++; if (sample_count !== 0) begin n_err++; $display("FAIL zero_count: got %0d expected 0", sample_count); end
    endtask

    task automatic test_gapped();
        bit pat [7] = '{1, 0, 1, 0, 1, 1, 1};
        bit rdy, er;
        int cyc;
        pulse_start(3);
        for (int i = 0; i < 7; i++) begin
            er = (m_rem != 0);
            offer(pat[i], W'($urandom), W'($urandom), 17'($urandom), 1'b0, rdy);
            n_cmp++; if (rdy !== er) begin n_err++; $display("FAIL gapped_ready[%0d]: got %b expected %b", i, rdy, er); end
        end
        wait_done(cyc);
        n_cmp++; if (done !== 1'b1 || sample_count !== 3) begin n_err++; $display("FAIL gapped_final: got done=%b count=%0d expected 1/3", done, sample_count); end
        n_cmp++; if (sum_ed !== 49'(m_sum) || max_ed !== 17'(m_max)) begin n_err++; $display("FAIL gapped_ed: got sum=%0d max=%0d expected %0d/%0d", sum_ed, max_ed, m_sum, m_max); end
        offer(1'b1, 16'h0001, 16'h0001, 17'h00000, 1'b0, rdy);
        offer(1'b0, '0, '0, '0, 1'b0, rdy);
        offer(1'b0, '0, '0, '0, 1'b0, rdy);
        n_cmp++; if (sample_count !== 3 || in_ready !== 1'b0) begin n_err++; $display("FAIL gapped_done_ignore: got count=%0d ready=%b expected 3/0", sample_count, in_ready); end
    endtask

    task automatic test_start_while_active();
        bit rdy;
        int cyc;
        pulse_start(4);
        cfg_count = 1;
        offer(1'b1, 16'h1000, 16'h1000, 17'h02100, 1'b0, rdy);
        offer(1'b1, 16'h0002, 16'h0003, 17'h00005, 1'b1, rdy);
        offer(1'b1, 16'h0004, 16'h0003, 17'h00007, 1'b0, rdy);
        offer(1'b1, 16'h0005, 16'h0003, 17'h00008, 1'b0, rdy);
        offer(1'b0, '0, '0, '0, 1'b1, rdy);
        wait_done(cyc);
        n_cmp++; if (sample_count !== 4 || max_ed !== 17'h100 || err_count !== 1) begin n_err++; $display("FAIL active_start_ignored: got count=%0d max=%0h err=%0d expected 4/100/1", sample_count, max_ed, err_count); end
        pulse_start(1);
        n_cmp++; if (max_ed !== 0 || sample_count !== 0 || busy !== 1'b1) begin n_err++; $display("FAIL done_restart_clear: got max=%0h count=%0d busy=%b expected 0/0/1", max_ed, sample_count, busy); end
        offer(1'b1, 16'h0010, 16'h0010, 17'h00021, 1'b0, rdy);
        wait_done(cyc);
        n_cmp++; if (max_ed !== 1 || sample_count !== 1 || done !== 1'b1) begin n_err++; $display("FAIL done_restart_run: got max=%0d count=%0d done=%b expected 1/1/1", max_ed, sample_count, done); end
    endtask

    // Randomized runs; run 0 keeps in_valid high for back-to-back throughput.
    task automatic test_random();
        bit rdy, er, v;
        int cyc, guard, mode;
        longint cnt;
        logic [W-1:0] a, b;
        logic [W:0] ex, s;
        for (int run = 0; run < 6; run++) begin
            cnt = (run == 0) ? 16 : longint'($urandom_range(1, 40));
            pulse_start(cnt);
            guard = 0;
            while (m_rem > 0 && guard < 400) begin
                v    = (run == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                a    = W'($urandom);
                b    = W'($urandom);
                ex   = {1'b0, a} + {1'b0, b};
                mode = $urandom_range(0, 3);
                case (mode)
                    0:       s = ex;
                    1:       s = ex + 17'($urandom_range(0, 6)) - 17'd3;
                    2:       s = 17'($urandom);
                    default: s = ex ^ 17'($urandom_range(0, 255));
                endcase
                er = (m_rem != 0);
                offer(v, a, b, s, 1'b0, rdy);
                n_cmp++; if (rdy !== er) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", run, rdy, er); end
                n_cmp++; if (sample_count !== CW'(m_cum_q[m_cum_q.size()-3])) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", run, sample_count, m_cum_q[m_cum_q.size()-3]); end
                guard++;
            end
            wait_done(cyc);
            if (run == 0) begin
                n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL b2b_done_latency: got %0d expected 3", cyc); end
            end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rand_done[%0d]: got %b expected 1", run, done); end
            n_cmp++; if (sample_count !== CW'(m_samples) || err_count !== CW'(m_errs)) begin n_err++; $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", run, sample_count, err_count, m_samples, m_errs); end
            n_cmp++; if (max_ed !== 17'(m_max) || sum_ed !== 49'(m_sum)) begin n_err++; $display("FAIL rand_ed[%0d]: got max=%0d sum=%0d expected %0d/%0d", run, max_ed, sum_ed, m_max, m_sum); end
            n_cmp++; if (err_bias !== 50'(exp_bias())) begin n_err++; $display("FAIL rand_bias[%0d]: got %0d expected %0d", run, err_bias, exp_bias()); end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_low_bit();
        test_zero_count();
        test_gapped();
        test_start_while_active();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axppa_error_monitor.md
# axppa_error_monitor

Streaming error-metric collector for the approximate prefix adders. Each sample is one operand pair plus the sum that the approximate adder under evaluation produced for it. The block recomputes the exact sum internally and accumulates the standard approximation metrics over a programmed number of samples:

- error rate
- maximum error distance
- summed error distance
- optional signed bias

It sits downstream of an approximate adder instance in characterisation and BIST harnesses.

## Interface
- WIDTH, 16, operand width; the approximate sum is WIDTH+1 bits
- CNT_W, 32, width of the sample and error counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; clears all statistics and arms a run (honoured only in IDLE or DONE)
- cfg_count  in  CNT_W  number of samples to accept in the run; sampled on start
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- op_a, op_b  in  WIDTH  operands given to the adder under test
- approx_sum  in  WIDTH+1  adder-under-test result, carry in MSB
- busy  out  1  state is RUN or DRAIN
- done  out  1  high in DONE
- sample_count  out  CNT_W  samples accumulated
- err_count  out  CNT_W  samples with approx_sum != exact sum
- max_ed  out  WIDTH+1  largest |exact - approx| seen
- sum_ed  out  CNT_W+WIDTH+1  sum of |exact - approx|
- err_bias  out  CNT_W+WIDTH+2 signed  sum of (approx - exact); see Configuration

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Transitions:
  - IDLE/DONE + start, cfg_count != 0 -> RUN. The start cycle clears all accumulators and latches cfg_count into the remaining-accept counter.
  - IDLE/DONE + start, cfg_count == 0 -> DONE. Accumulators are cleared; no sample is accepted.
  - RUN -> DRAIN on the handshake that accepts the last sample (remaining counter reaches 0).
  - DRAIN -> DONE once the pipeline holds no valid sample.
  - start in RUN or DRAIN is ignored.
- in_ready = (state == RUN). No backpressure exists beyond the state; the block accepts one sample per cycle.
- Pipeline:
  - S1 registers op_a, op_b, approx_sum and computes exact = op_a + op_b (WIDTH+1 bits, zero-extended, no carry-in).
  - S2 registers diff = approx - exact (WIDTH+2 bits signed), |diff| and mismatch = (diff != 0).
  - S3 is the accumulator update.
- Accumulator update per valid S2 entry:
  - sample_count += 1
  - err_count += mismatch
  - max_ed = max(max_ed, |diff|)
  - sum_ed += |diff|
  - err_bias += diff
- No counter can overflow for fewer than 2^CNT_W samples; widths are sized for that. No wrap handling is required.
- Statistic outputs are the accumulator registers and are live throughout the run. Values are final once done = 1 and hold until the next start or reset.
- Reset mid-run: everything clears asynchronously, pipeline valids clear and the FSM returns to IDLE. A sample whose handshake falls in the reset cycle is lost.

## Timing
- Reset values: in_ready 0, busy 0, done 0, every statistic output 0.
- Latency: a sample accepted at edge e0 is visible in the statistic outputs after edge e0+2.
- done rises at edge e0+3 relative to the final sample's acceptance edge.
- A start pulse at edge e clears the statistics after e; in_ready = 1 from then on, so the first accept can occur at e+1.
- Throughput: 1 sample per cycle, with no bubbles inserted.

## Configuration
- AXPPA_ERR_BIAS_EN defined: the signed err_bias accumulator and its S2 signed diff path are implemented.
- Undefined: err_bias is tied to 0, and only the unsigned |diff| path is built.
- All other behaviour is identical with or without the macro.

## Test plan
- **Reset:** assert rst_n = 0 mid-RUN after 3 samples -> all outputs 0 and state IDLE immediately; the next start works normally.
- **Exact samples:** cfg_count = 4, all approx_sum = op_a + op_b (e.g. 0x1234 + 0x0F0F -> 0x02143) -> sample_count 4, err_count 0, max_ed 0, sum_ed 0, done 3 cycles after the last accept.
- **Low-bit approximation:** cfg_count = 2.
  - Sample 1: op_a 0x003F, op_b 0x0001, approx_sum 0x0003E (exact 0x00040).
  - Sample 2: op_a 0xFFFF, op_b 0x0001, approx_sum 0x0FFFE (exact 0x10000).
  - Expected: err_count 2, max_ed 2, sum_ed 4, err_bias -4 (with AXPPA_ERR_BIAS_EN defined).
- **Zero-count run:** cfg_count = 0 with start -> DONE one cycle later; in_ready never asserts; statistics 0.
- **Gapped valid:** cfg_count = 3, in_valid toggled 1,0,1,0,1 -> exactly 3 accepts and in_ready low after the third; extra in_valid in DRAIN/DONE is ignored.
- **Start while active:** start pulsed during RUN is ignored with no counter clear. A start in DONE with cfg_count 1 clears the prior max_ed and restarts.
